// File: rtl/reg_file_if.sv
// reg_file_if: write-back write ports, decode read/issue ports and scoreboard status.
interface reg_file_if #(parameter int DATA_W = 16);
  logic              wr_low_en;
  logic [2:0]        wr_low_addr;
  logic [DATA_W-1:0] wr_low_data;
  logic              wr_high_en;
  logic [2:0]        wr_high_addr;
  logic [DATA_W-1:0] wr_high_data;
  logic [2:0]        rd_a_addr;
  logic [2:0]        rd_b_addr;
  logic [DATA_W-1:0] rd_a_data;
  logic [DATA_W-1:0] rd_b_data;
  logic              rd_a_busy;
  logic              rd_b_busy;
  logic              iss_low_en;
  logic [2:0]        iss_low_dst;
  logic              iss_high_en;
  logic [2:0]        iss_high_dst;
  logic              sb_err;
  modport slave (
    input  wr_low_en, wr_low_addr, wr_low_data, wr_high_en, wr_high_addr, wr_high_data,
    input  rd_a_addr, rd_b_addr, iss_low_en, iss_low_dst, iss_high_en, iss_high_dst,
    output rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, sb_err
  );
  modport master (
    output wr_low_en, wr_low_addr, wr_low_data, wr_high_en, wr_high_addr, wr_high_data,
    output rd_a_addr, rd_b_addr, iss_low_en, iss_low_dst, iss_high_en, iss_high_dst,
    input  rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, sb_err
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: 8x DATA_W register file, two write ports, two bypassed read ports,
// and a saturating per-register pending-write scoreboard with a sticky error flag.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_file_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [DATA_W-1:0] regs_q [8];
  logic [CNT_W-1:0]  cnt_q  [8];
  logic [CNT_W-1:0]  cnt_d  [8];
  logic [1:0]        dec    [8];
  logic              sb_err_q, sb_err_d;
  logic [1:0]        inc;
  logic [CNT_W+1:0]  nxt;
  // nxt is a two's-complement CNT_W+2 value: top bit flags underflow, bit CNT_W flags overflow
  always_comb begin
    sb_err_d = sb_err_q;
    inc = '0;
    nxt = '0;
    for (int r = 0; r < 8; r++) begin
      inc    = {1'b0, bus.iss_low_en && bus.iss_low_dst == 3'(r)} + {1'b0, bus.iss_high_en && bus.iss_high_dst == 3'(r)};
      dec[r] = {1'b0, bus.wr_low_en && bus.wr_low_addr == 3'(r)} + {1'b0, bus.wr_high_en && bus.wr_high_addr == 3'(r)};
      nxt    = {2'b00, cnt_q[r]} + (CNT_W+2)'(inc) - (CNT_W+2)'(dec[r]);
      cnt_d[r] = nxt[CNT_W+1] ? '0 : nxt[CNT_W] ? CNT_MAX : nxt[CNT_W-1:0];
      sb_err_d = sb_err_d | nxt[CNT_W+1] | nxt[CNT_W];
    end
  end
  assign bus.rd_a_data = (bus.wr_high_en && bus.wr_high_addr == bus.rd_a_addr) ? bus.wr_high_data :
                         (bus.wr_low_en  && bus.wr_low_addr  == bus.rd_a_addr) ? bus.wr_low_data  :
                         regs_q[bus.rd_a_addr];
  assign bus.rd_b_data = (bus.wr_high_en && bus.wr_high_addr == bus.rd_b_addr) ? bus.wr_high_data :
                         (bus.wr_low_en  && bus.wr_low_addr  == bus.rd_b_addr) ? bus.wr_low_data  :
                         regs_q[bus.rd_b_addr];
  assign bus.rd_a_busy = {2'b00, cnt_q[bus.rd_a_addr]} > (CNT_W+2)'(dec[bus.rd_a_addr]);
  assign bus.rd_b_busy = {2'b00, cnt_q[bus.rd_b_addr]} > (CNT_W+2)'(dec[bus.rd_b_addr]);
  assign bus.sb_err    = sb_err_q;
  // high port is written last so it wins an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (bus.wr_low_en)  regs_q[bus.wr_low_addr]  <= bus.wr_low_data;
      if (bus.wr_high_en) regs_q[bus.wr_high_addr] <= bus.wr_high_data;
      for (int r = 0; r < 8; r++) cnt_q[r] <= cnt_d[r];
      sb_err_q <= sb_err_d;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed steps for reg_file; expectations queued when driven, popped when sampled.
module tb_reg_file;
  logic clk, rst_n;
  int checks, errors;
  logic [15:0] exp_q [$];
  reg_file_if #(.DATA_W(16)) bus ();
  reg_file #(.DATA_W(16), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask
  task automatic chk(input string tag, input logic [15:0] got);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s got %h but no expected value queued", tag, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        errors++;
        $error("FAIL %s got %h expected %h", tag, got, e);
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.wr_low_en = 1'b0;
    bus.wr_high_en = 1'b0;
    bus.iss_low_en = 1'b0;
    bus.iss_high_en = 1'b0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.wr_low_en = 0; bus.wr_low_addr = 0; bus.wr_low_data = 0;
    bus.wr_high_en = 0; bus.wr_high_addr = 0; bus.wr_high_data = 0;
    bus.rd_a_addr = 3; bus.rd_b_addr = 0;
    bus.iss_low_en = 0; bus.iss_low_dst = 0; bus.iss_high_en = 0; bus.iss_high_dst = 0;
    #2;
    push(16'h0000); push(16'h0000); push(16'h0000);
    chk("rst_data", bus.rd_a_data);
    chk("rst_busy", 16'(bus.rd_a_busy));
    chk("rst_err", 16'(bus.sb_err));
    bus.wr_low_en = 1; bus.wr_low_addr = 3; bus.wr_low_data = 16'hAAAA;
    cyc();
    rst_n = 1'b1;
    push(16'h0000); #1; chk("drop_in_rst", bus.rd_a_data);
    cyc();
    bus.iss_low_en = 1; bus.iss_low_dst = 2; bus.iss_high_en = 1; bus.iss_high_dst = 5;
    cyc();
    bus.rd_a_addr = 2; bus.rd_b_addr = 5;
    push(16'h1); push(16'h1); #1;
    chk("iss_busy_a", 16'(bus.rd_a_busy));
    chk("iss_busy_b", 16'(bus.rd_b_busy));
    cyc();
    bus.wr_low_en = 1; bus.wr_low_addr = 2; bus.wr_low_data = 16'h1234;
    bus.wr_high_en = 1; bus.wr_high_addr = 5; bus.wr_high_data = 16'hBEEF;
    push(16'h1234); push(16'hBEEF); push(16'h0); push(16'h0); #1;
    chk("byp_a", bus.rd_a_data);
    chk("byp_b", bus.rd_b_data);
    chk("ret_busy_a", 16'(bus.rd_a_busy));
    chk("ret_busy_b", 16'(bus.rd_b_busy));
    cyc();
    push(16'h1234); push(16'hBEEF); push(16'h0); #1;
    chk("arr_a", bus.rd_a_data);
    chk("arr_b", bus.rd_b_data);
    chk("arr_err", 16'(bus.sb_err));
    cyc();
    bus.iss_low_en = 1; bus.iss_low_dst = 4; bus.iss_high_en = 1; bus.iss_high_dst = 4;
    cyc();
    bus.wr_low_en = 1; bus.wr_low_addr = 4; bus.wr_low_data = 16'h0001;
    bus.wr_high_en = 1; bus.wr_high_addr = 4; bus.wr_high_data = 16'hFFFF;
    bus.rd_a_addr = 4;
    push(16'hFFFF); #1; chk("col_byp", bus.rd_a_data);
    cyc();
    push(16'hFFFF); push(16'h0); #1;
    chk("col_arr", bus.rd_a_data);
    chk("col_err", 16'(bus.sb_err));
    cyc();
    bus.iss_low_en = 1; bus.iss_low_dst = 1; bus.rd_a_addr = 1;
    cyc();
    bus.iss_low_en = 1; bus.iss_low_dst = 1;
    push(16'h1); #1; chk("sb_busy1", 16'(bus.rd_a_busy));
    cyc();
    push(16'h1); #1; chk("sb_busy2", 16'(bus.rd_a_busy));
    cyc();
    bus.wr_low_en = 1; bus.wr_low_addr = 1; bus.wr_low_data = 16'h0011;
    push(16'h1); #1; chk("sb_ret1", 16'(bus.rd_a_busy));
    cyc();
    bus.wr_low_en = 1; bus.wr_low_addr = 1; bus.wr_low_data = 16'h0022;
    push(16'h0); push(16'h0022); #1;
    chk("sb_ret2", 16'(bus.rd_a_busy));
    chk("sb_byp", bus.rd_a_data);
    cyc();
    push(16'h0); push(16'h0); #1;
    chk("sb_idle", 16'(bus.rd_a_busy));
    chk("sb_err0", 16'(bus.sb_err));
    cyc();
    bus.iss_high_en = 1; bus.iss_high_dst = 6; bus.rd_a_addr = 6;
    cyc();
    bus.iss_high_en = 1; bus.iss_high_dst = 6;
    bus.wr_high_en = 1; bus.wr_high_addr = 6; bus.wr_high_data = 16'h0066;
    push(16'h0); #1; chk("sim_busy_now", 16'(bus.rd_a_busy));
    cyc();
    push(16'h1); push(16'h0); #1;
    chk("sim_busy_next", 16'(bus.rd_a_busy));
    chk("sim_err", 16'(bus.sb_err));
    cyc();
    bus.wr_high_en = 1; bus.wr_high_addr = 6; bus.wr_high_data = 16'h0067;
    push(16'h0); #1; chk("sim_clear", 16'(bus.rd_a_busy));
    cyc();
    bus.wr_low_en = 1; bus.wr_low_addr = 7; bus.wr_low_data = 16'h0007;
    bus.iss_low_en = 1; bus.iss_low_dst = 3;
    bus.rd_a_addr = 7; bus.rd_b_addr = 3;
    push(16'h0); #1; chk("under_err_pre", 16'(bus.sb_err));
    cyc();
    push(16'h1); push(16'h0); push(16'h0007); push(16'h1); #1;
    chk("under_err", 16'(bus.sb_err));
    chk("under_busy_r7", 16'(bus.rd_a_busy));
    chk("under_data_r7", bus.rd_a_data);
    chk("busy_r3", 16'(bus.rd_b_busy));
    cyc();
    rst_n = 1'b0; bus.rd_a_addr = 2;
    push(16'h0); push(16'h0); push(16'h0); #1;
    chk("rp_err", 16'(bus.sb_err));
    chk("rp_data_r2", bus.rd_a_data);
    chk("rp_busy_r3", 16'(bus.rd_b_busy));
    cyc();
    rst_n = 1'b1;
    bus.rd_a_addr = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.iss_low_en = 1; bus.iss_low_dst = 0;
    end
    push(16'h1); push(16'h0); #1;
    chk("sat_busy3", 16'(bus.rd_a_busy));
    chk("sat_err_pre", 16'(bus.sb_err));
    cyc();
    push(16'h1); push(16'h1); #1;
    chk("over_err", 16'(bus.sb_err));
    chk("over_busy", 16'(bus.rd_a_busy));
    cyc();
    bus.wr_low_en = 1; bus.wr_low_addr = 0; bus.wr_low_data = 16'h0100;
    cyc();
    bus.wr_low_en = 1; bus.wr_low_addr = 0; bus.wr_low_data = 16'h0200;
    push(16'h1); #1; chk("sat_ret2", 16'(bus.rd_a_busy));
    cyc();
    bus.wr_low_en = 1; bus.wr_low_addr = 0; bus.wr_low_data = 16'h0300;
    push(16'h0); #1; chk("sat_ret3", 16'(bus.rd_a_busy));
    cyc();
    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL leftover got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
